level_key_ctrl: RTL

//   Turns two raw active-low push-buttons (DE1-SoC KEY) into clean single-cycle inc/dec

---
 rtl/level_key_pkg.sv | 25 ++
 rtl/key_debounce.sv | 44 ++++
 rtl/level_key_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/level_key_pkg.sv
// Shared types and cycle constants for the KEY-to-step-pulse controller.
package level_key_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INC  = 2'd1,
        DEC  = 2'd2,
        LOCK = 2'd3
    } state_t;

    // Board timing at 50 MHz: 10 ms debounce, 0.5 s first repeat, 0.1 s repeat rate
    localparam int DEF_DEBOUNCE_CYC   = 500000;
    localparam int DEF_REPEAT_DLY_CYC = 25000000;
    localparam int DEF_REPEAT_CYC     = 5000000;

    // Shortened timing so simulation stays fast
    localparam int SIM_DEBOUNCE_CYC   = 4;
    localparam int SIM_REPEAT_DLY_CYC = 10;
    localparam int SIM_REPEAT_CYC     = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes one raw active-low key into the clock domain and debounces it.
module key_debounce
    import level_key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed
);

    localparam int               CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYC - 1);

    logic             ff1;
    logic             ff2;
    logic             db;
    logic [CNT_W-1:0] cnt;

    // The debounced level only follows ff2 once it has disagreed for DEBOUNCE_CYC cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1 <= 1'b1;
            ff2 <= 1'b1;
            db  <= 1'b1;
            cnt <= '0;
        end else begin
            ff1 <= key_n;
            ff2 <= ff1;
            if (ff2 == db) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                db  <= ff2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign pressed = ~db;

endmodule

// File: rtl/level_key_ctrl.sv
// Turns two debounced KEY buttons into one-cycle inc/dec pulses with auto-repeat
// and a lockout while both keys are held.
module level_key_ctrl
    import level_key_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DLY_CYC = DEF_REPEAT_DLY_CYC,
    parameter int REPEAT_CYC     = DEF_REPEAT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic key_inc_n,
    input  logic key_dec_n,
    output logic inc,
    output logic dec,
    output logic busy
);

    localparam int               RPT_W     = $clog2(max2(REPEAT_DLY_CYC, REPEAT_CYC));
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DLY_CYC - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_CYC - 1);

    logic             p_i;
    logic             p_d;
    state_t           state;
    logic [RPT_W-1:0] rpt;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
        .clk     (clk),
        .rst     (rst),
        .key_n   (key_inc_n),
        .pressed (p_i)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dec (
        .clk     (clk),
        .rst     (rst),
        .key_n   (key_dec_n),
        .pressed (p_d)
    );

    // Pulses default low every cycle so each one is exactly one cycle wide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rpt   <= '0;
            inc   <= 1'b0;
            dec   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            inc <= 1'b0;
            dec <= 1'b0;
            case (state)
                IDLE: begin
                    if (p_i && p_d) begin
                        state <= LOCK;
                        busy  <= 1'b1;
                    end else if (p_i) begin
                        state <= INC;
                        inc   <= 1'b1;
                        rpt   <= RPT_FIRST;
                        busy  <= 1'b1;
                    end else if (p_d) begin
                        state <= DEC;
                        dec   <= 1'b1;
                        rpt   <= RPT_FIRST;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                INC: begin
                    if (!p_i) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (p_d) begin
                        state <= LOCK;
                    end else if (rpt == '0) begin
                        inc   <= 1'b1;
                        rpt   <= RPT_NEXT;
                    end else begin
                        rpt   <= rpt - RPT_W'(1);
                    end
                end
                DEC: begin
                    if (!p_d) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (p_i) begin
                        state <= LOCK;
                    end else if (rpt == '0) begin
                        dec   <= 1'b1;
                        rpt   <= RPT_NEXT;
                    end else begin
                        rpt   <= rpt - RPT_W'(1);
                    end
                end
                LOCK: begin
                    // Only leave once both keys are released, so a half-release stays silent
                    if (!p_i && !p_d) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
